// File: rtl/mcif_read_ig_bpt8_if.sv
// Request/transaction bundle for the client-8 read-ingress burst-partition tracker.
// Handshake rule for both ports: a beat transfers on a clock edge where valid && ready; the source holds valid and payload stable until that edge.
interface mcif_read_ig_bpt8_if;
    logic        dma2bpt_req_valid;
    logic [76:0] dma2bpt_req_pd;
    logic        dma2bpt_req_ready;
    logic        bpt2arb_req8_valid;
    logic [74:0] bpt2arb_req8_pd;
    logic        bpt2arb_req8_ready;
    logic        rd_atoms_ret_vld;
    logic [3:0]  rd_atoms_ret;

    // Environment side: issues requests, accepts transactions, returns buffer atoms.
    modport master (
        output dma2bpt_req_valid, dma2bpt_req_pd, bpt2arb_req8_ready, rd_atoms_ret_vld, rd_atoms_ret,
        input  dma2bpt_req_ready, bpt2arb_req8_valid, bpt2arb_req8_pd
    );

    // Tracker side.
    modport slave (
        input  dma2bpt_req_valid, dma2bpt_req_pd, bpt2arb_req8_ready, rd_atoms_ret_vld, rd_atoms_ret,
        output dma2bpt_req_ready, bpt2arb_req8_valid, bpt2arb_req8_pd
    );
endinterface

// File: rtl/mcif_read_ig_bpt8.sv
// Splits one DMA read request into <=8-atom, 256B-contained transactions for MCIF client 8.
// Optional latency-credit throttling is enabled by defining MCIF_READ_IG_BPT8_LAT_CREDIT_EN.
module mcif_read_ig_bpt8 #(
    parameter logic [3:0] AXID        = 4'd8,
    parameter int         LAT_ENTRIES = 64
) (
    input  logic                      nvdla_core_clk,
    input  logic                      nvdla_core_rstn,
    mcif_read_ig_bpt8_if.slave        bpt_if,
    output logic                      o_dbg_state
);
    typedef enum logic {ST_IDLE = 1'b0, ST_SPLIT = 1'b1} state_t;

    state_t      r_state;
    logic [63:0] r_cur_addr;
    logic [13:0] r_remain;
    logic        r_valid;
    logic [74:0] r_pd;

    logic        w_hs;
    logic [3:0]  w_cur_n;
    logic [63:0] w_adv_addr;
    logic [13:0] w_adv_remain;
    logic [63:0] w_src_addr;
    logic [13:0] w_src_remain;
    logic        w_src_first;
    logic [3:0]  w_room;
    logic [3:0]  w_src_n;
    logic [3:0]  w_src_nm1;
    logic        w_src_last;
    logic [74:0] w_src_pd;
    logic [3:0]  w_chk_n;
    logic        w_credit_ok;

    assign w_hs         = r_valid & bpt_if.bpt2arb_req8_ready;
    assign w_cur_n      = {1'b0, r_pd[70:68]} + 4'd1;
    assign w_adv_addr   = r_cur_addr + {55'd0, w_cur_n, 5'd0};
    assign w_adv_remain = r_remain - {10'd0, w_cur_n};

    // The "source" is the transaction to be registered next: a fresh request in IDLE, the advanced pointer in SPLIT.
    assign w_src_first  = (r_state == ST_IDLE);
    assign w_src_addr   = w_src_first ? {bpt_if.dma2bpt_req_pd[63:5], 5'd0} : w_adv_addr;
    assign w_src_remain = w_src_first ? ({1'b0, bpt_if.dma2bpt_req_pd[76:64]} + 14'd1) : w_adv_remain;
    assign w_room       = 4'd8 - {1'b0, w_src_addr[7:5]};
    assign w_src_n      = (w_src_remain < {10'd0, w_room}) ? w_src_remain[3:0] : w_room;
    assign w_src_nm1    = w_src_n - 4'd1;
    assign w_src_last   = (w_src_remain == {10'd0, w_src_n});
    assign w_src_pd     = {w_src_first, w_src_last, w_src_n[0], w_src_addr[5], w_src_nm1[2:0], w_src_addr, AXID};

    // A stalled-but-not-yet-valid transaction re-checks its own size; otherwise the next one is checked.
    assign w_chk_n = ((r_state == ST_SPLIT) && !w_hs) ? w_cur_n : w_src_n;

`ifdef MCIF_READ_IG_BPT8_LAT_CREDIT_EN
    localparam logic [7:0] LP_LAT = LAT_ENTRIES[7:0];

    logic [7:0] r_credit;
    logic [9:0] w_credit_full;
    logic [7:0] w_credit_next;

    assign w_credit_full = {2'd0, r_credit}
                         + (bpt_if.rd_atoms_ret_vld ? {6'd0, bpt_if.rd_atoms_ret} : 10'd0)
                         - (w_hs ? {6'd0, w_cur_n} : 10'd0);
    assign w_credit_next = (w_credit_full > {2'd0, LP_LAT}) ? LP_LAT : w_credit_full[7:0];
    assign w_credit_ok   = (w_credit_next >= {4'd0, w_chk_n});

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_credit <= LP_LAT;
        end else begin
            r_credit <= w_credit_next;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (nvdla_core_rstn) begin
            assert (w_credit_full <= {2'd0, LP_LAT})
                else $error("bpt8 credit overflow: %0d > %0d", w_credit_full, LP_LAT);
        end
    end
`else
    logic w_unused_ret;
    assign w_unused_ret = ^{bpt_if.rd_atoms_ret_vld, bpt_if.rd_atoms_ret, w_chk_n};
    assign w_credit_ok  = 1'b1;
`endif

    always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
        if (!nvdla_core_rstn) begin
            r_state    <= ST_IDLE;
            r_cur_addr <= 64'd0;
            r_remain   <= 14'd0;
            r_valid    <= 1'b0;
            r_pd       <= 75'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bpt_if.dma2bpt_req_valid) begin
                        r_cur_addr <= w_src_addr;
                        r_remain   <= w_src_remain;
                        r_pd       <= w_src_pd;
                        r_valid    <= w_credit_ok;
                        r_state    <= ST_SPLIT;
                    end
                end
                ST_SPLIT: begin
                    if (w_hs) begin
                        if (r_pd[73]) begin
                            r_valid <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_cur_addr <= w_adv_addr;
                            r_remain   <= w_adv_remain;
                            r_pd       <= w_src_pd;
                            r_valid    <= w_credit_ok;
                        end
                    end else if (!r_valid) begin
                        r_valid <= w_credit_ok;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bpt_if.dma2bpt_req_ready  = (r_state == ST_IDLE);
    assign bpt_if.bpt2arb_req8_valid = r_valid;
    assign bpt_if.bpt2arb_req8_pd    = r_pd;
    assign o_dbg_state               = (r_state == ST_SPLIT);
endmodule

// File: tb/tb_mcif_read_ig_bpt8.sv
// Directed + randomized bench for mcif_read_ig_bpt8 with a packet scoreboard.
module tb_mcif_read_ig_bpt8;
`ifdef MCIF_READ_IG_BPT8_LAT_CREDIT_EN
    localparam int LAT = 8;
`else
    localparam int LAT = 64;
`endif

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic dbg_state;

    mcif_read_ig_bpt8_if bus();

    mcif_read_ig_bpt8 #(.AXID(4'd8), .LAT_ENTRIES(LAT)) dut (
        .nvdla_core_clk  (clk),
        .nvdla_core_rstn (rstn),
        .bpt_if          (bus),
        .o_dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [74:0] exp_q[$];
    int ready_mode = 0;
    bit auto_ret = 1'b0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [74:0] pkt(input logic [63:0] a, input int n, input bit lt, input bit ft);
        logic [2:0] nm1;
        nm1 = 3'(n - 1);
        return {ft, lt, n[0], a[5], nm1, a, 4'd8};
    endfunction

    function automatic void push_model(input logic [63:0] a, input int size);
        logic [63:0] cur;
        int rem;
        int room;
        int n;
        bit ft;
        cur = {a[63:5], 5'd0};
        rem = size + 1;
        ft  = 1'b1;
        while (rem > 0) begin
            room = 8 - int'(cur[7:5]);
            n    = (rem < room) ? rem : room;
            exp_q.push_back(pkt(cur, n, rem == n, ft));
            cur  = cur + 64'(n * 32);
            rem  = rem - n;
            ft   = 1'b0;
        end
    endfunction

    // Monitor: handshakes are sampled mid-cycle and take effect at the following rising edge.
    initial begin : monitor
        logic [74:0] prev_pd;
        bit prev_stall;
        logic [74:0] e;
        prev_stall = 1'b0;
        prev_pd = '0;
        forever begin
            @(negedge clk);
            if (!rstn) begin
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_valid", bus.bpt2arb_req8_valid, 1);
                    check("stall_pd", bus.bpt2arb_req8_pd, prev_pd);
                end
                if (bus.bpt2arb_req8_valid && bus.bpt2arb_req8_ready) begin
                    total++;
                    assert (exp_q.size() > 0) else begin
                        bad++;
                        $error("FAIL unexpected_txn observed=%0h expected=none", bus.bpt2arb_req8_pd);
                    end
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("txn_pd", bus.bpt2arb_req8_pd, e);
                    end
                end
                prev_stall = bus.bpt2arb_req8_valid && !bus.bpt2arb_req8_ready;
                prev_pd = bus.bpt2arb_req8_pd;
            end
        end
    end

    // Downstream ready pattern, plus automatic buffer returns one cycle after each accepted transaction.
    initial begin : ready_drv
        bit hs;
        logic [3:0] hs_n;
        bit tog;
        tog = 1'b0;
        forever begin
            @(negedge clk);
            hs   = rstn && bus.bpt2arb_req8_valid && bus.bpt2arb_req8_ready;
            hs_n = {1'b0, bus.bpt2arb_req8_pd[70:68]} + 4'd1;
            @(posedge clk);
            #1;
            case (ready_mode)
                0: bus.bpt2arb_req8_ready = 1'b1;
                1: bus.bpt2arb_req8_ready = 1'b0;
                2: begin tog = ~tog; bus.bpt2arb_req8_ready = tog; end
                default: bus.bpt2arb_req8_ready = 1'($urandom_range(0, 1));
            endcase
            if (auto_ret) begin
                bus.rd_atoms_ret_vld = hs;
                bus.rd_atoms_ret = hs_n;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic send_req(input logic [63:0] a, input logic [12:0] sz, input bit chk_lat);
        int cyc;
        cyc = 0;
        bus.dma2bpt_req_valid = 1'b1;
        bus.dma2bpt_req_pd = {sz, a};
        @(negedge clk);
        while (!bus.dma2bpt_req_ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("req_accept_timeout", cyc < 100, 1);
        @(posedge clk);
        #1;
        bus.dma2bpt_req_valid = 1'b0;
        bus.dma2bpt_req_pd = {13'($urandom), $urandom, $urandom};
        if (chk_lat) begin
            check("req_ready_busy", bus.dma2bpt_req_ready, 0);
            check("first_valid_latency", bus.bpt2arb_req8_valid, 1);
        end
    endtask

    task automatic wait_drain(input string tag);
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || !bus.dma2bpt_req_ready || bus.rd_atoms_ret_vld) && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_drain"}, cyc < 400, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin : main
        logic [63:0] ra;
        int rs;
        bus.dma2bpt_req_valid = 1'b0;
        bus.dma2bpt_req_pd = '0;
        bus.bpt2arb_req8_ready = 1'b0;
        bus.rd_atoms_ret_vld = 1'b0;
        bus.rd_atoms_ret = 4'd0;
`ifdef MCIF_READ_IG_BPT8_LAT_CREDIT_EN
        auto_ret = 1'b1;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", bus.dma2bpt_req_ready, 1);
        check("rst_valid", bus.bpt2arb_req8_valid, 0);
        check("rst_pd", bus.bpt2arb_req8_pd, 0);
        check("rst_state", dbg_state, 0);
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // 10 atoms from offset 0x40: 6 up to the 256B boundary, then 4.
        ready_mode = 0;
        exp_q.push_back(pkt(64'h1000_0040, 6, 1'b0, 1'b1));
        exp_q.push_back(pkt(64'h1000_0100, 4, 1'b1, 1'b0));
        send_req(64'h1000_0040, 13'd9, 1'b1);
`ifndef MCIF_READ_IG_BPT8_LAT_CREDIT_EN
        @(posedge clk);
        #1;
        check("back_to_back_valid", bus.bpt2arb_req8_valid, 1);
`endif
        wait_drain("split10");

        // Single atom: request port must reopen right after the only handshake.
        exp_q.push_back(pkt(64'h20, 1, 1'b1, 1'b1));
        send_req(64'h20, 13'd0, 1'b1);
        @(posedge clk);
        #1;
        check("single_req_ready_back", bus.dma2bpt_req_ready, 1);
        check("single_valid_drop", bus.bpt2arb_req8_valid, 0);
        wait_drain("single");

        // Address wrap past 2^64.
        exp_q.push_back(pkt(64'hFFFF_FFFF_FFFF_FFE0, 1, 1'b0, 1'b1));
        exp_q.push_back(pkt(64'h0, 1, 1'b1, 1'b0));
        send_req(64'hFFFF_FFFF_FFFF_FFE7, 13'd1, 1'b0);
        wait_drain("wrap");

        // 64 atoms under stall then toggling ready.
        ready_mode = 1;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(pkt(64'(i * 256), 8, i == 7, i == 0));
        end
        send_req(64'h0, 13'd63, 1'b1);
        repeat (5) @(posedge clk);
        ready_mode = 2;
        wait_drain("stall64");

        // Randomized requests against the splitting model.
        ready_mode = 3;
        for (int i = 0; i < 6; i++) begin
            ra = {$urandom, $urandom};
            if (i == 0) ra[63:8] = '1;
            rs = $urandom_range(0, 40);
            push_model(ra, rs);
            send_req(ra, 13'(rs), 1'b0);
            wait_drain("random");
        end

        // Reset in the middle of a 3-transaction split.
        ready_mode = 0;
        @(posedge clk);
        #1;
        exp_q.push_back(pkt(64'h2000, 8, 1'b0, 1'b1));
        send_req(64'h2000, 13'd23, 1'b1);
        @(posedge clk);
        #3;
        rstn = 1'b0;
        #1;
        check("midrst_valid", bus.bpt2arb_req8_valid, 0);
        check("midrst_pd", bus.bpt2arb_req8_pd, 0);
        check("midrst_first_seen", exp_q.size(), 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        @(posedge clk);
        #1;
        check("postrst_req_ready", bus.dma2bpt_req_ready, 1);
        check("postrst_valid", bus.bpt2arb_req8_valid, 0);
        exp_q.push_back(pkt(64'h40, 3, 1'b1, 1'b1));
        send_req(64'h40, 13'd2, 1'b1);
        wait_drain("postrst");

`ifdef MCIF_READ_IG_BPT8_LAT_CREDIT_EN
        // Credit exhaustion: the second 8-atom transaction waits for a return.
        repeat (2) @(posedge clk);
        #1;
        auto_ret = 1'b0;
        bus.rd_atoms_ret_vld = 1'b0;
        exp_q.push_back(pkt(64'h0, 8, 1'b0, 1'b1));
        exp_q.push_back(pkt(64'h100, 8, 1'b1, 1'b0));
        send_req(64'h0, 13'd15, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check("credit_blocked", bus.bpt2arb_req8_valid, 0);
        end
        bus.rd_atoms_ret_vld = 1'b1;
        bus.rd_atoms_ret = 4'd8;
        @(negedge clk);
        check("credit_ret_cycle", bus.bpt2arb_req8_valid, 0);
        @(posedge clk);
        #1;
        bus.rd_atoms_ret_vld = 1'b0;
        check("credit_valid_after_ret", bus.bpt2arb_req8_valid, 1);
        @(posedge clk);
        #1;
        bus.rd_atoms_ret_vld = 1'b1;
        bus.rd_atoms_ret = 4'd8;
        @(posedge clk);
        #1;
        bus.rd_atoms_ret_vld = 1'b0;
        wait_drain("credit");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mcif_read_ig_bpt8.md
# mcif_read_ig_bpt8

Read-ingress burst-partition tracker (BPT) for MCIF client 8. Accepts one DMA read request (64-bit address, length in 32B atoms) and splits it into memory transactions of at most 8 atoms that never cross a 256B boundary. Each transaction is emitted as a 75-bit packet on a valid/ready port. That port feeds directly into client 8's skid pipe stage ahead of the ingress arbiter. An optional latency-credit check throttles emission against read-return buffer space.

## Interface
- AXID, default 4'd8: AXI ID stamped into every transaction.
- LAT_ENTRIES, default 64: read-return buffer size in atoms, 1..255. Used only with the credit feature.
- nvdla_core_clk  in  1  core clock.
- nvdla_core_rstn  in  1  reset, asynchronous, active-low.
- dma2bpt_req_valid  in  1  request valid.
- dma2bpt_req_pd  in  77  request: [63:0] byte address, bits [4:0] ignored and treated as 0; [76:64] atoms-1.
- dma2bpt_req_ready  out  1  request accepted.
- bpt2arb_req8_valid  out  1  transaction valid.
- bpt2arb_req8_pd  out  75  transaction packet:
  - [3:0] axid
  - [67:4] address
  - [70:68] atoms-1
  - [71] swizzle
  - [72] odd
  - [73] ltran
  - [74] ftran
- bpt2arb_req8_ready  in  1  downstream accept.
- rd_atoms_ret_vld  in  1  read-return buffer freed atoms.
- rd_atoms_ret  in  4  atoms freed, 1..8.

## Operation
- States are IDLE and SPLIT. dma2bpt_req_ready = (state==IDLE).
- IDLE: on req_valid & req_ready, capture:
  - cur_addr = {addr[63:5],5'b0}
  - remain = size+1 (14 bits, range 1..8192)
  - first = 1
  - Go to SPLIT.
- SPLIT: the current transaction's atom count is n = min(remain, 8 - cur_addr[7:5]).
  - The rule applies to every transaction; after the first, cur_addr is 256B-aligned, so n = min(remain, 8).
- Packet fields:
  - address = cur_addr
  - atoms-1 = n-1
  - swizzle = cur_addr[5]
  - odd = n[0]
  - ftran = first
  - ltran = (remain==n)
  - axid = AXID
- On bpt2arb handshake:
  - cur_addr += n*32, modulo 2^64 (wraps to 0).
  - remain -= n.
  - first = 0.
  - If ltran, return to IDLE.
- While valid & !ready, pd and valid are held stable. Valid never drops without a handshake, except on reset.

## Timing
- Reset values:
  - dma2bpt_req_ready=1
  - bpt2arb_req8_valid=0
  - bpt2arb_req8_pd=0
  - state IDLE
  - credit counter = LAT_ENTRIES
- Request accepted at cycle N gives first transaction valid at N+1. Under continuous ready, one transaction is issued per cycle.
- Last handshake at cycle M gives req_ready=1 at M+1. There is one bubble cycle between requests.
- valid and pd are driven from registers; there is no combinational path from ready inputs to outputs.
- Asynchronous reset mid-SPLIT discards the in-flight request immediately. No partial tail is emitted.

## Configuration
- MCIF_READ_IG_BPT8_LAT_CREDIT_EN defined:
  - An 8-bit credit counter starts at LAT_ENTRIES.
  - bpt2arb_req8_valid is asserted only when credit >= n.
  - Handshake subtracts n. rd_atoms_ret_vld adds rd_atoms_ret.
  - A handshake and a return in the same cycle apply both: credit + ret - n.
  - Credit never exceeds LAT_ENTRIES. An overflowing return saturates and fires a simulation assertion.
  - Once valid is asserted, it stays high until handshake.
- Not defined:
  - There is no counter. rd_atoms_ret* are ignored.
  - Valid is asserted every SPLIT cycle.

## Test plan
- addr 0x1000_0040, size 9 (10 atoms), ready=1:
  - First transaction: addr 0x1000_0040, atoms-1=5, ftran=1, ltran=0, swizzle=0, odd=0.
  - Second transaction: addr 0x1000_0100, atoms-1=3, ftran=0, ltran=1, odd=0.
- addr 0x0000_0020, size 0 -> single transaction: atoms-1=0, ftran=ltran=1, swizzle=1, odd=1, axid=8. req_ready returns to 1 on the following cycle.
- addr 0xFFFF_FFFF_FFFF_FFE0, size 1:
  - First transaction: 1 atom at 0xFFFF_FFFF_FFFF_FFE0.
  - Second transaction: 1 atom at address 0x0 with ltran=1.
- addr 0x0, size 63, ready low 5 cycles, then toggling -> 8 transactions of 8 atoms each at 0x0, 0x100, … 0x700. pd is bit-stable during every stall.
- Credit enabled, LAT_ENTRIES=8, two back-to-back 8-atom aligned requests:
  - The second transaction stays invalid until rd_atoms_ret_vld with rd_atoms_ret=8.
  - That transaction's valid asserts on the cycle after the return.
- Reset asserted in SPLIT after the first of 3 transactions -> valid=0 immediately, req_ready=1 after release. The next request emits from its own ftran.
